// File: rtl/mem_responder_if.sv
// Write, read-request and read-response channels of the memory responder.
// Master drives requests and rsp_ready; slave returns readies, errors and responses.
interface mem_responder_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDRSIZE   = 2
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDRSIZE-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_err;

  logic                  rd_valid;
  logic                  rd_ready;
  logic [ADDRSIZE-1:0]   rd_addr;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready,
    input  wr_ready, wr_err, rd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready,
    output wr_ready, wr_err, rd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Small register-file responder: always-ready writes, single-register read response
// with latency 1, write-first collisions and error responses for unwritten locations.
module mem_responder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_ADDR   = 4,
  localparam int unsigned ADDRSIZE  = (MAX_ADDR > 1) ? $clog2(MAX_ADDR) : 1
) (
  input logic            clk,
  input logic            rst_n,
  mem_responder_if.slave bus
);

  // One extra bit so MAX_ADDR itself is representable for the range compare.
  localparam logic [ADDRSIZE:0] MaxAddr = (ADDRSIZE + 1)'(MAX_ADDR);

  logic [DATA_WIDTH-1:0] mem_q [MAX_ADDR];
  logic [MAX_ADDR-1:0]   written_q;

  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  wr_err_q;

  logic wr_fire, rd_fire, rsp_fire;
  logic wr_in_range, rd_in_range, collide;

  assign bus.wr_ready  = rst_n;
  assign bus.rd_ready  = rst_n & (~rsp_valid_q | bus.rsp_ready);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.wr_err    = wr_err_q;

  assign wr_fire  = bus.wr_valid & bus.wr_ready;
  assign rd_fire  = bus.rd_valid & bus.rd_ready;
  assign rsp_fire = rsp_valid_q & bus.rsp_ready;

  assign wr_in_range = ({1'b0, bus.wr_addr} < MaxAddr);
  assign rd_in_range = ({1'b0, bus.rd_addr} < MaxAddr);
  assign collide     = wr_fire & wr_in_range & rd_in_range & (bus.wr_addr == bus.rd_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAX_ADDR; i++) begin
        mem_q[i] <= '0;
      end
      written_q <= '0;
    end else if (wr_fire && wr_in_range) begin
      mem_q[bus.wr_addr]     <= bus.wr_data;
      written_q[bus.wr_addr] <= 1'b1;
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    if (rd_fire) begin
      rsp_valid_d = 1'b1;
      if (collide) begin
        // Write-first: the word landing this edge is what the reader sees.
        rsp_data_d = bus.wr_data;
        rsp_err_d  = 1'b0;
      end else if (rd_in_range && written_q[bus.rd_addr]) begin
        rsp_data_d = mem_q[bus.rd_addr];
        rsp_err_d  = 1'b0;
      end else begin
        rsp_data_d = '0;
        rsp_err_d  = 1'b1;
      end
    end else if (rsp_fire) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      wr_err_q    <= wr_fire & ~wr_in_range;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed plus random stimulus for mem_responder, checked against a behavioural
// model with a response scoreboard; MAX_ADDR = 6 so out-of-range addresses exist.
module tb_mem_responder;
  localparam int unsigned DW  = 8;
  localparam int unsigned MAX = 6;
  localparam int unsigned AW  = 3;
  localparam int unsigned NA  = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_responder_if #(.DATA_WIDTH(DW), .ADDRSIZE(AW)) bus ();

  mem_responder #(.DATA_WIDTH(DW), .MAX_ADDR(MAX)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] m_mem [NA];
  logic          m_wr  [NA];
  logic          m_valid;
  logic          m_wr_err;
  logic [DW:0]   sb [$];  // {err, data}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NA; i++) begin
      m_mem[i] = '0;
      m_wr[i]  = 1'b0;
    end
    m_valid  = 1'b0;
    m_wr_err = 1'b0;
    sb.delete();
  endtask

  // One clock cycle: drive at negedge, check settled outputs, update model at posedge.
  task automatic tick(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic rv, input logic [AW-1:0] ra, input logic rr);
    logic        exp_rd_ready, wf, rf, sf;
    logic [DW:0] rsp;
    @(negedge clk);
    bus.wr_valid  = wv;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    bus.rd_valid  = rv;
    bus.rd_addr   = ra;
    bus.rsp_ready = rr;
    #1;
    exp_rd_ready = ~m_valid | rr;
    check("wr_ready", 32'(bus.wr_ready), 32'd1);
    check("rd_ready", 32'(bus.rd_ready), 32'(exp_rd_ready));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
    check("wr_err", 32'(bus.wr_err), 32'(m_wr_err));
    if (m_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL scoreboard: observed empty expected entry");
      end else begin
        check("rsp_data", 32'(bus.rsp_data), 32'(sb[0][DW-1:0]));
        check("rsp_err", 32'(bus.rsp_err), 32'(sb[0][DW]));
      end
    end
    wf = wv;
    rf = rv & exp_rd_ready;
    sf = m_valid & rr;
    rsp = '0;
    if (rf) begin
      if (wf && (wa < MAX) && (wa == ra)) rsp = {1'b0, wd};
      else if ((ra < MAX) && m_wr[ra])    rsp = {1'b0, m_mem[ra]};
      else                                rsp = {1'b1, {DW{1'b0}}};
    end
    @(posedge clk);
    if (sf) void'(sb.pop_front());
    if (rf) sb.push_back(rsp);
    m_valid  = rf | (m_valid & ~sf);
    m_wr_err = wf & ~(wa < MAX);
    if (wf && (wa < MAX)) begin
      m_mem[wa] = wd;
      m_wr[wa]  = 1'b1;
    end
  endtask

  task automatic idle(input logic rr);
    tick(1'b0, '0, '0, 1'b0, '0, rr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'd0);
    check({tag, "_rd_ready"}, 32'(bus.rd_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
    check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    check({tag, "_wr_err"}, 32'(bus.wr_err), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_valid  = 1'b0;
    bus.rd_addr   = '0;
    bus.rsp_ready = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;

    // Unwritten read returns error
    tick(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b1);
    idle(1'b1);

    // Write then read
    tick(1'b1, 3'd0, 8'h05, 1'b0, 3'd0, 1'b1);
    tick(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1);
    idle(1'b1);

    // Same-edge collision on a never-written location
    tick(1'b1, 3'd1, 8'h06, 1'b1, 3'd1, 1'b1);
    idle(1'b1);

    // Stalled response holds while writes continue
    tick(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b0);
    repeat (3) tick(1'b1, 3'd0, 8'h09, 1'b1, 3'd0, 1'b0);
    tick(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1);
    idle(1'b1);

    // Back-to-back reads
    for (int a = 0; a < 4; a++) tick(1'b0, 3'd0, 8'h00, 1'b1, 3'(a), 1'b1);
    idle(1'b1);

    // Boundaries: last valid location, first invalid, top of address space
    tick(1'b1, 3'd5, 8'hA5, 1'b0, 3'd0, 1'b1);
    tick(1'b1, 3'd6, 8'h33, 1'b1, 3'd5, 1'b1);
    tick(1'b1, 3'd7, 8'h44, 1'b1, 3'd6, 1'b1);
    tick(1'b1, 3'd7, 8'h55, 1'b1, 3'd7, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      tick(1'($urandom), 3'($urandom_range(0, 7)), 8'($urandom % 10),
           1'($urandom), 3'($urandom_range(0, 7)), 1'($urandom));
    end

    // Asynchronous reset mid-run with requests pending
    @(negedge clk);
    bus.wr_valid  = 1'b1;
    bus.rd_valid  = 1'b1;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("hold");
    model_clear();
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
    rst_n = 1'b1;

    for (int a = 0; a < NA; a++) tick(1'b0, 3'd0, 8'h00, 1'b1, 3'(a), 1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of every data word.
REQ-002 Parameter MAX_ADDR, default 4, number of storage locations; ADDRSIZE = $clog2(MAX_ADDR).
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 wr_valid  input  1  write request present.
REQ-006 wr_ready  output  1  write request can be accepted.
REQ-007 wr_addr  input  ADDRSIZE  write location.
REQ-008 wr_data  input  DATA_WIDTH  write word.
REQ-009 wr_err  output  1  one-cycle pulse: accepted write was dropped.
REQ-010 rd_valid  input  1  read request present.
REQ-011 rd_ready  output  1  read request can be accepted.
REQ-012 rd_addr  input  ADDRSIZE  read location.
REQ-013 rsp_valid  output  1  read response present.
REQ-014 rsp_ready  input  1  consumer takes response.
REQ-015 rsp_data  output  DATA_WIDTH  read response word.
REQ-016 rsp_err  output  1  response is an error (rsp_data = 0).

Function
REQ-017 Write handshake: wr_fire = wr_valid & wr_ready; read handshake: rd_fire = rd_valid & rd_ready; response handshake: rsp_fire = rsp_valid & rsp_ready.
REQ-018 wr_ready SHALL be 1 whenever rst_n is high and 0 while rst_n is low.
REQ-019 On wr_fire with wr_addr < MAX_ADDR: mem[wr_addr] <= wr_data and written[wr_addr] <= 1 at that edge.
REQ-020 On wr_fire with wr_addr >= MAX_ADDR: no storage change; wr_err = 1 for exactly the following cycle.
REQ-021 rd_ready SHALL equal !rsp_valid | rsp_ready (single output register, no bubble under continuous flow).
REQ-022 On rd_fire, rsp_valid = 1 in the next cycle (latency 1) with rsp_data/rsp_err from the read at that edge.
REQ-023 Read response content: rd_addr >= MAX_ADDR or written[rd_addr] = 0 -> rsp_err = 1, rsp_data = 0; otherwise rsp_err = 0, rsp_data = mem[rd_addr].
REQ-024 Same-edge collision (wr_fire & rd_fire, equal in-range addresses): write-first -- response carries wr_data with rsp_err = 0, even if the location was never written before.
REQ-025 Collision with different addresses: both proceed independently, no stall.
REQ-026 While rsp_valid & !rsp_ready: rsp_data and rsp_err SHALL hold stable, rd_ready = 0; writes continue and do not alter the held response.
REQ-027 On rsp_fire without rd_fire: rsp_valid = 0 next cycle; on rsp_fire with rd_fire: rsp_valid stays 1 with the new response.
REQ-028 rsp_valid SHALL never drop without rsp_fire (except reset).

Reset
REQ-029 While rst_n = 0: wr_ready = 0, rd_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0, wr_err = 0.
REQ-030 Reset SHALL clear all written[] flags and all mem[] words to 0.
REQ-031 Reset asserted mid-transaction discards any pending response; no request is considered accepted at an edge where rst_n = 0.
REQ-032 First handshake is possible on the first posedge after rst_n deasserts.

Verification
REQ-033 Reset, then read addr 2 with rsp_ready = 1 -> next cycle rsp_valid = 1, rsp_err = 1, rsp_data = 0.
REQ-034 Write 0x05 to addr 0, next cycle read addr 0 -> rsp_data = 0x05, rsp_err = 0, one cycle after rd_fire.
REQ-035 Same edge: write 0x06 to addr 1 and read addr 1 (never written) -> rsp_data = 0x06, rsp_err = 0.
REQ-036 Read addr 0 with rsp_ready = 0 for 3 cycles while writing 0x09 to addr 0 -> rsp_data holds 0x05, rd_ready = 0 throughout; after rsp_ready = 1, next read of addr 0 returns 0x09.
REQ-037 Back-to-back reads addr 0,1,2,3 every cycle with rsp_ready = 1 -> four consecutive rsp_valid cycles, no bubble, data in order.
REQ-038 Random wr_valid/rd_valid/rsp_ready, wr_data = $random % 10, checked against a reference model; assert rst_n low mid-run -> all outputs 0, subsequent reads of any addr return rsp_err = 1.
